tic_toc_game_ctrl: RTL

Turn sequencer and referee for the tic-tac-toe board datapath. It alternates move eligibility between player and computer and validates each requested one-hot move against its own shadow board. Accepted moves become single-cycle one-hot write strobes to the position registers. It also detects win, draw and turn timeout, and raises no_space and invalid_move for the datapath.

---
 rtl/tic_toc_game_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tic_toc_game_ctrl.sv
// -----------------------------------------------------------------------------
// tic_toc_game_ctrl
//
// Turn sequencer and referee for the tic-tac-toe board datapath. It alternates
// move eligibility between player and computer, validates each one-hot move
// request against a shadow board, turns accepted moves into single-cycle
// one-hot write strobes, and detects win, draw and turn timeout.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          begin a new game (honoured in IDLE and DONE only)
//   first_is_comp  sampled with start: 1 = computer moves first
//   plyr_valid     player request qualifier
//   plyr_move      player one-hot position request, bit0 = p1 .. bit8 = p9
//   comp_valid     computer request qualifier
//   comp_move      computer one-hot position request
//   plyr_turn      player is eligible to mark
//   comp_turn      computer is eligible to mark
//   plyr_wr        one-cycle write strobe for an accepted player move
//   comp_wr        one-cycle write strobe for an accepted computer move
//   invalid_move   one-cycle pulse when the active side's request is rejected
//   no_space       all 9 positions occupied
//   game_over      high while the game is finished
//   winner         00 none/draw, 01 player, 10 computer
//   move_count     accepted moves this game, 0..9
//   board          shadow board {p9..p1}, 2 bits each: 00 empty, 01 plyr, 10 comp
//   timeout        game ended by a turn timeout
// -----------------------------------------------------------------------------
module tic_toc_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        first_is_comp,
    input  logic        plyr_valid,
    input  logic [8:0]  plyr_move,
    input  logic        comp_valid,
    input  logic [8:0]  comp_move,
    output logic        plyr_turn,
    output logic        comp_turn,
    output logic [8:0]  plyr_wr,
    output logic [8:0]  comp_wr,
    output logic        invalid_move,
    output logic        no_space,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_count,
    output logic [17:0] board,
    output logic        timeout
);

    typedef enum logic [2:0] {S_IDLE, S_PLYR, S_COMP, S_CHECK, S_DONE} state_t;

    localparam logic [1:0] CODE_PLYR = 2'b01;
    localparam logic [1:0] CODE_COMP = 2'b10;

    // Counter value on the last allowed cycle of a turn; meaningless when the
    // timeout is disabled, which the enable bit guards.
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [17:0]      board_nxt;
    logic [3:0]       count_nxt;
    logic [1:0]       winner_nxt;
    logic             timeout_nxt;
    logic [8:0]       plyr_wr_nxt, comp_wr_nxt;
    logic             invalid_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mover_comp, mover_comp_nxt;

    logic             act_valid;
    logic [8:0]       act_move;
    logic             one_hot;
    logic             occupied;
    logic             legal;

    // True if any of the 8 lines is fully owned by the given side code.
    function automatic logic line_owned(input logic [17:0] b, input logic [1:0] code);
        logic [8:0] own;
        for (int i = 0; i < 9; i++) own[i] = (b[2*i +: 2] == code);
        return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
               (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
               (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++) full &= (b[2*i +: 2] != 2'b00);
        return full;
    endfunction

    // Only the side whose turn it is gets looked at; the other is ignored.
    always_comb begin
        act_valid = 1'b0;
        act_move  = '0;
        if (state == S_PLYR) begin
            act_valid = plyr_valid;
            act_move  = plyr_move;
        end else if (state == S_COMP) begin
            act_valid = comp_valid;
            act_move  = comp_move;
        end
    end

    always_comb begin
        one_hot  = (act_move != 9'd0) && ((act_move & (act_move - 9'd1)) == 9'd0);
        occupied = 1'b0;
        for (int i = 0; i < 9; i++) occupied |= act_move[i] & (board[2*i +: 2] != 2'b00);
        legal    = act_valid && one_hot && !occupied;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        board_nxt      = board;
        count_nxt      = move_count;
        winner_nxt     = winner;
        timeout_nxt    = timeout;
        plyr_wr_nxt    = '0;
        comp_wr_nxt    = '0;
        invalid_nxt    = 1'b0;
        cnt_nxt        = cnt;
        mover_comp_nxt = mover_comp;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    board_nxt   = '0;
                    count_nxt   = '0;
                    winner_nxt  = 2'b00;
                    timeout_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = first_is_comp ? S_COMP : S_PLYR;
                end
            end

            S_PLYR, S_COMP: begin
                if (legal) begin
                    for (int i = 0; i < 9; i++)
                        if (act_move[i])
                            board_nxt[2*i +: 2] = (state == S_COMP) ? CODE_COMP : CODE_PLYR;
                    if (state == S_COMP) comp_wr_nxt = act_move;
                    else                 plyr_wr_nxt = act_move;
                    count_nxt      = move_count + 4'd1;
                    mover_comp_nxt = (state == S_COMP);
                    state_nxt      = S_CHECK;
                end else begin
                    invalid_nxt = act_valid;
                    // A rejected request does not restart the turn timer.
                    if (TIMEOUT_EN && cnt == TO_LAST) begin
                        winner_nxt  = (state == S_COMP) ? CODE_PLYR : CODE_COMP;
                        timeout_nxt = 1'b1;
                        state_nxt   = S_DONE;
                    end else if (TIMEOUT_EN) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            S_CHECK: begin
                if (line_owned(board, mover_comp ? CODE_COMP : CODE_PLYR)) begin
                    winner_nxt = mover_comp ? CODE_COMP : CODE_PLYR;
                    state_nxt  = S_DONE;
                end else if (move_count == 4'd9) begin
                    winner_nxt = 2'b00;
                    state_nxt  = S_DONE;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = mover_comp ? S_PLYR : S_COMP;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            board        <= '0;
            move_count   <= '0;
            winner       <= 2'b00;
            timeout      <= 1'b0;
            plyr_wr      <= '0;
            comp_wr      <= '0;
            invalid_move <= 1'b0;
            no_space     <= 1'b0;
            cnt          <= '0;
            mover_comp   <= 1'b0;
        end else begin
            board        <= board_nxt;
            move_count   <= count_nxt;
            winner       <= winner_nxt;
            timeout      <= timeout_nxt;
            plyr_wr      <= plyr_wr_nxt;
            comp_wr      <= comp_wr_nxt;
            invalid_move <= invalid_nxt;
            // Registered alongside the board so it rises with the 9th write.
            no_space     <= board_full(board_nxt);
            cnt          <= cnt_nxt;
            mover_comp   <= mover_comp_nxt;
        end
    end

    assign plyr_turn = (state == S_PLYR);
    assign comp_turn = (state == S_COMP);
    assign game_over = (state == S_DONE);

endmodule
